// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial stream, pattern load and match result bundle
interface seq_detector_param_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic load;
  logic [WIDTH-1:0] pattern;
  logic mode;
  logic in_valid;
  logic in;
  logic out;
  logic [CNT_W-1:0] count;
  modport master (output load, pattern, mode, in_valid, in, input out, count);
  modport slave (input load, pattern, mode, in_valid, in, output out, count);
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: sliding-window pattern detector; SEQ_DETECTOR_COUNT_EN enables the match counter
module seq_detector_param #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  seq_detector_param_if.slave bus
);
  typedef enum logic {FILLING, ARMED} state_t;
  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FULL = FW'(WIDTH);
  localparam logic [FW-1:0] ARM = FW'(WIDTH - 1);
  logic [WIDTH-1:0] pat_q, hist, hist_d, cand;
  logic mode_q, out_q, hit;
  logic [FW-1:0] fill, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t state;
  assign state = (fill >= ARM) ? ARMED : FILLING;
  assign cand = {hist[WIDTH-2:0], bus.in};
  always_comb begin
    hit = bus.in_valid && !bus.load && state == ARMED && cand == pat_q;
    hist_d = bus.load ? '0 : bus.in_valid ? cand : hist;
    fill_d = bus.load ? '0 :
             !bus.in_valid ? fill :
             (hit && !mode_q) ? '0 :
             (fill == FULL) ? fill : fill + 1'b1;
`ifdef SEQ_DETECTOR_COUNT_EN
    cnt_d = bus.load ? '0 : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
`else
    cnt_d = '0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      mode_q <= 1'b1;
      hist <= '0;
      fill <= '0;
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (bus.load) begin
        pat_q <= bus.pattern;
        mode_q <= bus.mode;
      end
      hist <= hist_d;
      fill <= fill_d;
      out_q <= hit;
      cnt_q <= cnt_d;
    end
  end
  assign bus.out = out_q;
  assign bus.count = cnt_q;
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the next generation of the fixed-pattern `Detector`. It samples a qualified serial bit stream and compares a sliding window of the last `WIDTH` bits against a runtime-loadable pattern. It supports overlapping and non-overlapping match modes and a saturating match counter. It sits directly on a serial receive line, with `Out` feeding downstream framing/control logic.

## Interface
- `WIDTH`, 4: pattern length in bits, 2..32.
- `CNT_W`, 8: match counter width, 1..16.
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: asynchronous, active-low reset.
- `Load` in 1: latch `Pattern` and `Mode`; flush history.
- `Pattern` in WIDTH: pattern to detect. MSB is the first bit received.
- `Mode` in 1: 1 = overlapping, 0 = non-overlapping. Latched on `Load`.
- `In_Valid` in 1: `In` is sampled only when high.
- `In` in 1: serial data bit.
- `Out` out 1: one-cycle match pulse.
- `Count` out CNT_W: number of matches since the last reset or `Load`.

## Operation
- Internal state:
  - `pat_q[WIDTH-1:0]` and `mode_q`: latched pattern and mode.
  - `hist[WIDTH-1:0]`: shift register. The new bit enters at the LSB and the oldest bit sits at the MSB.
  - `fill`: count of valid history bits, 0..WIDTH, saturating at WIDTH.
- States (encoded by `fill`):
  - FILLING: `fill` < WIDTH-1. No match is possible.
  - ARMED: `fill` ≥ WIDTH-1. The next valid bit can complete a match.
- Sample edge (`In_Valid`=1, `Load`=0):
  - The candidate window is `{hist[WIDTH-2:0], In}`.
  - Match = ARMED and candidate == `pat_q`.
  - On a match:
    - `Out` is set to 1 for the next cycle.
    - `Count` increments, saturating at 2^CNT_W−1 with no wrap.
  - Overlapping mode (`mode_q`=1): `hist` takes the candidate, `fill` increments (saturating). The matched bits may begin a new match.
  - Non-overlapping mode (`mode_q`=0), on a match: `fill` clears to 0 (`hist` contents become don't-care). The next match needs WIDTH fresh bits.
  - With no match, in either mode: shift the history and increment `fill`.
- `In_Valid`=0: `hist`, `fill` and `Count` hold; `Out`=0.
- `Load`=1:
  - `pat_q`←`Pattern`, `mode_q`←`Mode`.
  - `fill`, `hist` and `Count` clear to 0; `Out`=0.
  - `Load` has priority over a simultaneous `In_Valid`; that bit is discarded.
- `Rst` low, at any time including mid-stream: all registers clear immediately.
  - `pat_q`=0, `mode_q`=1 (overlapping), `hist`=0, `fill`=0, `Out`=0, `Count`=0.

## Timing
- All outputs are registered.
- Reset values: `Out`=0, `Count`=0.
- Match latency: `Out` is high in the cycle immediately after the edge that sampled the last pattern bit, for exactly one cycle. `Count` updates on the same edge.
- Back-to-back matches: possible on consecutive valid bits in overlapping mode only, and only when the pattern allows it (e.g. all-ones). `Out` then stays high for consecutive cycles.
- Non-overlapping mode: minimum spacing between `Out` pulses is WIDTH valid bits.
- Gaps: `In_Valid` gaps of any length are transparent to detection. Only valid bits count.
- First match after reset or `Load`: no earlier than the WIDTH-th valid bit.
- Reset release: the first sample is on the first rising edge after `Rst` deasserts.

## Configuration
- `SEQ_DETECTOR_COUNT_EN`:
  - Defined: the match counter is implemented as specified.
  - Undefined: the counter logic is removed and `Count` is tied to 0. `Out` behaviour is unchanged.

## Test plan
All scenarios use WIDTH=4 and CNT_W=8 unless stated.

- Overlap basic: reset, `Load` with `Pattern`=4'b1001, `Mode`=1, stream 1,0,0,1,0,0,1 (all valid) -> `Out` pulses after bits 4 and 7; `Count`=2.
- Non-overlap: same stream with `Mode`=0 -> a single `Out` pulse after bit 4; `Count`=1.
- Gaps and early bits: `Pattern`=4'b1111, `Mode`=1, ones with `In_Valid` toggling 1,0,1,0… -> no `Out` before the 4th valid bit; `Out` then pulses on every later valid bit and is 0 during the gaps.
- Saturation (macro defined, CNT_W=2): `Pattern`=4'b1111, `Mode`=1, 10 valid ones -> 7 pulses; `Count` sticks at 3.
- Load/reset mid-operation:
  - After 3 bits of 1,0,0, assert `Load` with `Pattern`=4'b0011 together with `In_Valid`=1 -> that bit is dropped; a subsequent 0,0,1,1 gives exactly one pulse and `Count`=1.
  - Pulling `Rst` low mid-stream -> `Out` and `Count` go to 0 asynchronously.
- Macro undefined: rerun the overlap-basic scenario -> identical `Out` pulses; `Count` is 0 throughout.
